processor_debug_host: RTL and testbench
=======================================

// Module: processor_debug_host
// PURPOSE
//  Host-side partner of the staged processor's wait/continue and debug interfaces.
//  Takes byte commands from a host link, such as a UART receiver, with valid/ready.
//  It reports halt status, pulses continue, and reads r0..r7/ip through the debug port.
//  Register values are returned to the host as little-endian response bytes.
// PARAMETERS
//  WORD_SIZE      18  processor word width; supported range 9..24
//  SETTLE_CYCLES  1   cycles between driving debug_reg_addr and sampling debug_data_out; must be >=1
// PORTS
//  clock                    in   1          single system clock
//  reset                    in   1          synchronous, active-high
//  cmd_valid                in   1          host command byte valid
//  cmd_data                 in   8          host command byte
//  cmd_ready                out  1          byte accepted when cmd_valid && cmd_ready
//  rsp_valid                out  1          response byte valid
//  rsp_data                 out  8          response byte
//  rsp_ready                in   1          host consumes byte when rsp_valid && rsp_ready
//  wait_for_continue        in   1          processor halted on a wait instruction
//  wait_continue_execution  out  1          one-cycle pulse that resumes the processor
//  debug_get_param          out  1          stops the processor and enables the debug read mux
//  debug_reg_addr           out  4          register select: 0..7 = r0..r7, 8 = ip
//  debug_data_out           in   WORD_SIZE  selected register value
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE. Any partial command or pending response is dropped.
//  Reset applied mid-operation behaves the same way. cmd_ready is 1 from the first cycle after reset.
//  Bytes per word: NB = (WORD_SIZE+7)/8. Bytes go LSB first; unused top bits of the last byte are 0.
//  Response handshake: rsp_valid and rsp_data stay stable while rsp_ready is low.
//  rsp_valid never drops until the byte is taken.
//  cmd_ready is 1 only in IDLE and GET_ARG. No command bytes are consumed while a response is pending.
//  Commands (first byte):
//   0x01 STATUS    -> respond {7'b0, wait_for_continue}, sampled on the accept cycle.
//   0x02 CONTINUE  -> if wait_for_continue=1: assert wait_continue_execution for exactly 1 cycle (CONT_PULSE),
//                     then respond 0x02. Otherwise no pulse and respond 0xE0 (not halted).
//   0x03 DUMP      -> requires wait_for_continue=1, otherwise respond 0xE0.
//                     Reads addresses 0..8 in order and sends 9*NB bytes (27 bytes at default).
//   0x04 READ_REG  -> next byte is the address (GET_ARG).
//                     Address <=8: respond with NB bytes of that register.
//                     Address >8: respond 0xE1. 0x04 does not require halt: debug_get_param stops the processor.
//   other          -> respond 0xEE.
//  Register read sequence: assert debug_get_param and drive debug_reg_addr in SETUP.
//   Wait SETTLE_CYCLES, then capture debug_data_out into a word register (CAPTURE).
//   Serialize it (SEND), then step to the next address or finish.
//   debug_get_param stays 1 for the whole DUMP and clears on return to IDLE.
//   debug_reg_addr holds its last value in IDLE.
//  States: IDLE, GET_ARG, CONT_PULSE, SETUP, CAPTURE, SEND, RESP1 (single-byte reply).
//   All reply paths return to IDLE once the last byte is taken.
//  Edge cases:
//   - wait_for_continue falling mid-DUMP is ignored; the dump completes.
//   - wait_continue_execution is never asserted together with debug_get_param.
//   - A rsp_ready stall during SEND holds debug_reg_addr and debug_get_param unchanged.
//   - Back-to-back commands: a new command is accepted on the cycle after the last response byte is taken.
// STRUCTURE
//  Package processor_debug_pkg holds:
//   - command codes: CMD_STATUS, CMD_CONTINUE, CMD_DUMP, CMD_READ_REG
//   - response codes: RSP_NOT_HALTED=0xE0, RSP_BAD_ADDR=0xE1, RSP_BAD_CMD=0xEE
//   - DEBUG_REG_IP=8, DEBUG_REG_COUNT=9
//   - the state enum
//  Sub-module debug_word_serializer: loads a WORD_SIZE word and emits NB bytes LSB first on rsp_valid/rsp_ready.
//   It raises a done pulse after the last byte is taken.
// TESTING
//  1. Reset mid-SEND of DUMP -> next cycle all outputs 0, cmd_ready=1, no further bytes.
//  2. STATUS with wait_for_continue=1 -> single byte 0x01. With wait_for_continue=0 -> 0x00.
//  3. CONTINUE while halted -> wait_continue_execution high exactly 1 cycle, then byte 0x02.
//     CONTINUE while running -> 0xE0 and no pulse.
//  4. DUMP with r0..r7=0x00001..0x00008 and ip=0x3FFFF, halted -> 27 bytes: 01 00 00, 02 00 00 ... 08 00 00, FF FF 03.
//     Run with random rsp_ready stalls; debug_get_param must stay high throughout.
//  5. READ_REG 0x04,0x05 with r5=0x2A5A5 -> A5 A5 02. READ_REG 0x04,0x09 -> 0xE1. Opcode 0x7F -> 0xEE.
//  6. Parameter run with WORD_SIZE=24, SETTLE_CYCLES=3 -> NB=3 with full-width bytes.
//     debug_data_out is sampled exactly 3 cycles after each address change.

Source files
------------

// File: rtl/processor_debug_pkg.sv
// Shared definitions for the processor debug host: host command and
// response codes, debug register map, and the controller state encoding.
package processor_debug_pkg;

  // Host command opcodes (first byte of a command)
  localparam logic [7:0] CMD_STATUS   = 8'h01;
  localparam logic [7:0] CMD_CONTINUE = 8'h02;
  localparam logic [7:0] CMD_DUMP     = 8'h03;
  localparam logic [7:0] CMD_READ_REG = 8'h04;

  // Single-byte replies
  localparam logic [7:0] RSP_CONT_OK    = 8'h02;
  localparam logic [7:0] RSP_NOT_HALTED = 8'hE0;
  localparam logic [7:0] RSP_BAD_ADDR   = 8'hE1;
  localparam logic [7:0] RSP_BAD_CMD    = 8'hEE;

  // Debug register map: 0..7 are r0..r7, 8 is the instruction pointer
  localparam logic [3:0] DEBUG_REG_IP    = 4'd8;
  localparam int         DEBUG_REG_COUNT = 9;

  typedef enum logic [2:0] {
    IDLE,
    GET_ARG,
    CONT_PULSE,
    SETUP,
    CAPTURE,
    SEND,
    RESP1
  } state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// Loads one WORD_SIZE word and emits it as (WORD_SIZE+7)/8 bytes, LSB first,
// on a valid/ready byte stream. Unused top bits of the last byte are zero.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   load, word           capture a new word (only issued while idle)
//   rsp_valid/rsp_data   byte stream out, stable until taken
//   rsp_ready            consumer accepts the byte
//   done                 high in the cycle the last byte is taken
module debug_word_serializer #(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] word,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  output logic                 done
);
  localparam int NB = (WORD_SIZE + 7) / 8;
  localparam int PW = NB * 8;
  localparam int CW = $clog2(NB + 1);

  logic [PW-1:0] shreg;
  logic [CW-1:0] left;

  assign rsp_valid = (left != '0);
  assign rsp_data  = shreg[7:0];
  // Combinational so the owner can move on in the same edge the last byte
  // leaves, allowing the next host command one cycle later.
  assign done      = rsp_valid && rsp_ready && (left == CW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
      left  <= '0;
    end else if (load) begin
      shreg <= PW'(word);
      left  <= CW'(NB);
    end else if (rsp_valid && rsp_ready) begin
      // Shifting in zeros leaves rsp_data at 0 once the word is drained.
      shreg <= shreg >> 8;
      left  <= left - 1'b1;
    end
  end

endmodule

// File: rtl/processor_debug_host.sv
// Host-side controller for the staged processor's wait/continue and debug
// read ports. Accepts byte commands (STATUS, CONTINUE, DUMP, READ_REG),
// pulses continue, reads r0..r7/ip and returns little-endian response bytes.
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   cmd_valid/cmd_data/cmd_ready     host command byte stream in
//   rsp_valid/rsp_data/rsp_ready     response byte stream out
//   wait_for_continue                processor halted on a wait instruction
//   wait_continue_execution          one-cycle resume pulse
//   debug_get_param                  stops processor, enables the debug read mux
//   debug_reg_addr                   debug register select (0..8)
//   debug_data_out                   selected register value
module processor_debug_host
  import processor_debug_pkg::*;
#(
  parameter int WORD_SIZE     = 18,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t               state, state_n;
  logic [3:0]           addr_q, addr_n;
  logic                 dump_q, dump_n;
  logic [7:0]           resp_q, resp_n;
  logic [SW-1:0]        settle_q, settle_n;
  logic [WORD_SIZE-1:0] word_q;
  logic                 cmd_fire, settle_done;
  logic                 ser_valid, ser_done;
  logic [7:0]           ser_data;

  assign cmd_fire    = cmd_valid && cmd_ready;
  // debug_data_out is sampled on the edge that ends the last SETUP cycle,
  // i.e. SETTLE_CYCLES edges after debug_reg_addr changed.
  assign settle_done = (state == SETUP) && (settle_q == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      dump_q   <= 1'b0;
      resp_q   <= '0;
      settle_q <= '0;
      word_q   <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      dump_q   <= dump_n;
      resp_q   <= resp_n;
      settle_q <= settle_n;
      if (settle_done) word_q <= debug_data_out;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    dump_n   = dump_q;
    resp_n   = resp_q;
    settle_n = settle_q;
    case (state)
      IDLE: if (cmd_fire) begin
        case (cmd_data)
          CMD_STATUS: begin
            resp_n  = {7'b0, wait_for_continue};
            state_n = RESP1;
          end
          CMD_CONTINUE:
            if (wait_for_continue) state_n = CONT_PULSE;
            else begin
              resp_n  = RSP_NOT_HALTED;
              state_n = RESP1;
            end
          CMD_DUMP:
            if (wait_for_continue) begin
              addr_n   = '0;
              dump_n   = 1'b1;
              settle_n = '0;
              state_n  = SETUP;
            end else begin
              resp_n  = RSP_NOT_HALTED;
              state_n = RESP1;
            end
          CMD_READ_REG: state_n = GET_ARG;
          default: begin
            resp_n  = RSP_BAD_CMD;
            state_n = RESP1;
          end
        endcase
      end
      GET_ARG: if (cmd_fire) begin
        if (cmd_data <= {4'b0, DEBUG_REG_IP}) begin
          addr_n   = cmd_data[3:0];
          dump_n   = 1'b0;
          settle_n = '0;
          state_n  = SETUP;
        end else begin
          resp_n  = RSP_BAD_ADDR;
          state_n = RESP1;
        end
      end
      CONT_PULSE: begin
        resp_n  = RSP_CONT_OK;
        state_n = RESP1;
      end
      SETUP:
        if (settle_done) state_n = CAPTURE;
        else settle_n = settle_q + 1'b1;
      CAPTURE: state_n = SEND;
      SEND: if (ser_done) begin
        // Halt is not re-checked here: a dump always runs to the ip word.
        if (dump_q && addr_q != DEBUG_REG_IP) begin
          addr_n   = addr_q + 4'd1;
          settle_n = '0;
          state_n  = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      RESP1: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  debug_word_serializer #(.WORD_SIZE(WORD_SIZE)) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (state == CAPTURE),
    .word      (word_q),
    .rsp_valid (ser_valid),
    .rsp_data  (ser_data),
    .rsp_ready (rsp_ready),
    .done      (ser_done)
  );

  assign cmd_ready               = (state == IDLE) || (state == GET_ARG);
  assign wait_continue_execution = (state == CONT_PULSE);
  assign debug_get_param         = (state == SETUP) || (state == CAPTURE) || (state == SEND);
  assign debug_reg_addr          = addr_q;
  assign rsp_valid               = (state == RESP1) || ser_valid;
  assign rsp_data                = (state == RESP1) ? resp_q : ser_data;

endmodule

// File: tb/tb_processor_debug_host.sv
// Bench for processor_debug_host: two configurations (18-bit/settle 1 and
// 24-bit/settle 3) run directed and random commands; expected bytes are
// queued on command accept and checked by an independent monitor.
module tb_processor_debug_host;

  typedef struct {
    logic [7:0] b;
    bit         rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit fin [2];

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int WS = (g == 0) ? 18 : 24;
    localparam int SC = (g == 0) ? 1 : 3;
    localparam int NB = (WS + 7) / 8;

    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_data = '0;
    logic          cmd_ready, rsp_valid, wce, dgp;
    logic          rsp_ready = 1'b0;
    logic          wfc = 1'b0;
    logic [7:0]    rsp_data;
    logic [3:0]    dra;
    logic [WS-1:0] ddo = '0;

    processor_debug_host #(.WORD_SIZE(WS), .SETTLE_CYCLES(SC)) dut (
      .clock                   (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_data                (cmd_data),
      .cmd_ready               (cmd_ready),
      .rsp_valid               (rsp_valid),
      .rsp_data                (rsp_data),
      .rsp_ready               (rsp_ready),
      .wait_for_continue       (wfc),
      .wait_continue_execution (wce),
      .debug_get_param         (dgp),
      .debug_reg_addr          (dra),
      .debug_data_out          (ddo)
    );

    exp_t          q[$];
    logic [WS-1:0] regs [9];
    int            pulses_exp = 0;
    int            pulses_seen = 0;
    int            last_take = -10;
    bit            in_reset = 1'b1;
    bit            hold = 1'b0;
    logic [7:0]    hold_data = '0;
    bit            wce_prev = 1'b0;

    // Register file model: the true value is visible only in the cycle that
    // is exactly SC cycles after the address (or get_param) changed, so a
    // capture at any other time yields the inverted value.
    int         age = 0;
    logic       dgp_q = 1'b0;
    logic [3:0] dra_q = '0;
    always @(posedge clk) begin
      #1;
      if (dgp && (!dgp_q || dra != dra_q)) age = 1;
      else age = age + 1;
      dgp_q = dgp;
      dra_q = dra;
      if (dra <= 4'd8) ddo = (dgp && age == SC) ? regs[dra] : ~regs[dra];
      else ddo = '0;
    end

    // Monitor: random backpressure, byte compare, hold and pulse checks.
    always @(negedge clk) begin : mon
      exp_t e;
      if (in_reset) begin
        rsp_ready = 1'b0;
        hold      = 1'b0;
        wce_prev  = 1'b0;
      end else begin
        if (wce) begin
          pulses_seen++;
          chk("cont_with_get_param", {31'b0, dgp}, 0);
          chk("cont_pulse_width", {31'b0, wce_prev}, 0);
        end
        wce_prev = wce;
        if (hold) chk("rsp_hold", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, hold_data});
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (rsp_valid && rsp_ready) begin
          if (q.size() == 0) chk("unexpected_byte", {24'b0, rsp_data}, 32'hFFFF_FFFF);
          else begin
            e = q.pop_front();
            chk("rsp_byte", {24'b0, rsp_data}, {24'b0, e.b});
            chk("get_param_during_byte", {31'b0, dgp}, {31'b0, e.rd});
          end
          last_take = cyc + 1;
          hold = 1'b0;
        end else begin
          hold = rsp_valid;
        end
        hold_data = rsp_data;
      end
    end

    task automatic send_byte(input logic [7:0] b, input bit halted, output bit ok);
      int n;
      bit waited;
      n = 0;
      waited = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      wfc       = halted;
      while (!cmd_ready && n < 2000) begin
        waited = 1'b1;
        n++;
        @(negedge clk);
      end
      ok = cmd_ready;
      if (!ok) chk("cmd_accept_timeout", 0, 1);
      else begin
        if (waited) chk("back_to_back_accept", cyc + 1, last_take + 1);
        @(posedge clk);
        #1;
      end
      cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [WS-1:0] w);
      for (int i = 0; i < NB; i++) q.push_back('{b: 8'(w >> (8 * i)), rd: 1'b1});
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg, input bit halted);
      bit ok;
      send_byte(op, halted, ok);
      if (ok) begin
        case (op)
          8'h01: q.push_back('{b: {7'b0, halted}, rd: 1'b0});
          8'h02:
            if (halted) begin
              pulses_exp++;
              q.push_back('{b: 8'h02, rd: 1'b0});
            end else q.push_back('{b: 8'hE0, rd: 1'b0});
          8'h03:
            if (halted) for (int a = 0; a < 9; a++) push_word(regs[a]);
            else q.push_back('{b: 8'hE0, rd: 1'b0});
          8'h04: begin
            send_byte(arg, halted, ok);
            if (ok) begin
              if (arg <= 8) push_word(regs[arg[3:0]]);
              else q.push_back('{b: 8'hE1, rd: 1'b0});
            end
          end
          default: q.push_back('{b: 8'hEE, rd: 1'b0});
        endcase
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || !cmd_ready) && n < 5000) begin
        n++;
        @(negedge clk);
      end
      chk("drain_left", q.size(), 0);
    endtask

    initial begin : drv
      int  n;
      bit  seen;
      int  r;
      logic [7:0] op;
      for (int a = 0; a < 9; a++) regs[a] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("reset_outputs", {21'b0, rsp_valid, rsp_data, wce, dgp}, 0);
      chk("reset_addr", {28'b0, dra}, 0);
      reset    = 1'b0;
      in_reset = 1'b0;

      // STATUS / CONTINUE, halted and running
      do_cmd(8'h01, 0, 1'b1);
      do_cmd(8'h01, 0, 1'b0);
      do_cmd(8'h02, 0, 1'b1);
      do_cmd(8'h02, 0, 1'b0);
      drain();

      // DUMP with r0..r7 = 1..8 and ip = 0x3FFFF; halt drops mid-dump
      for (int a = 0; a < 8; a++) regs[a] = WS'(a + 1);
      regs[8] = WS'(18'h3FFFF);
      do_cmd(8'h03, 0, 1'b1);
      wfc = 1'b0;
      drain();

      // READ_REG, bad address, bad opcode
      regs[5] = WS'(18'h2A5A5);
      do_cmd(8'h04, 8'h05, 1'b0);
      do_cmd(8'h04, 8'h09, 1'b0);
      do_cmd(8'h7F, 0, 1'b0);
      drain();

      // Reset in the middle of a dump
      do_cmd(8'h03, 0, 1'b1);
      n = 0;
      while (q.size() > 9 * NB - 4 && n < 2000) begin
        n++;
        @(negedge clk);
      end
      @(negedge clk);
      in_reset = 1'b1;
      reset    = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      chk("midreset_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("midreset_outputs", {21'b0, rsp_valid, rsp_data, wce, dgp}, 0);
      chk("midreset_addr", {28'b0, dra}, 0);
      reset    = 1'b0;
      hold     = 1'b0;
      wce_prev = 1'b0;
      in_reset = 1'b0;
      seen = 1'b0;
      repeat (30) begin
        @(negedge clk);
        seen |= rsp_valid;
      end
      chk("quiet_after_reset", {31'b0, seen}, 0);

      // Random commands, issued back to back
      for (int a = 0; a < 9; a++) regs[a] = WS'($urandom);
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) op = 8'h01;
        else if (r < 4) op = 8'h02;
        else if (r < 6) op = 8'h03;
        else if (r < 9) op = 8'h04;
        else op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
        do_cmd(op, 8'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));
      end
      drain();
      chk("continue_pulses", pulses_seen, pulses_exp);
      fin[g] = 1'b1;
    end
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(fin[0] && fin[1]) && n < 60000) begin
      n++;
      @(posedge clk);
    end
    chk("global_timeout", {30'b0, fin[1], fin[0]}, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
